// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring unsigned divide/remainder, one op in flight.
module seq_alu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_DIVU = 4'd10;
    localparam logic [3:0] OP_REMU = 4'd11;
    localparam logic [3:0] OP_NOR  = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Results available at accept; DIVU/REMU entries only matter for b == 0.
    function automatic logic [XLEN-1:0] fast_result(
        input logic [3:0]      f_op,
        input logic [XLEN-1:0] x,
        input logic [XLEN-1:0] y
    );
        logic [XLEN-1:0] r;
        case (f_op)
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_SLT:  r = ($signed(x) < $signed(y)) ? XLEN'(1) : {XLEN{1'b0}};
            OP_NOR:  r = ~(x | y);
            OP_DIVU: r = {XLEN{1'b1}};
            OP_REMU: r = x;
            default: r = {XLEN{1'b0}};
        endcase
        return r;
    endfunction

    state_t          state_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic [XLEN-1:0] result_r;
    logic            zero_r;
    logic [3:0]      op_r;
    logic [XLEN-1:0] a_r;    // multiplicand (MUL) or dividend/quotient shifter (DIV)
    logic [XLEN-1:0] b_r;    // multiplier (MUL) or divisor (DIV)
    logic [XLEN-1:0] acc_r;  // partial product (MUL) or partial remainder (DIV)
    logic [CW-1:0]   cnt_r;

    logic [XLEN-1:0] fast_s;
    logic            multi_s;
    logic [XLEN-1:0] mul_sum_s;
    logic [XLEN:0]   rem_sh_s;
    logic [XLEN:0]   diff_s;
    logic            ge_s;
    logic [XLEN-1:0] rem_nx_s;
    logic [XLEN-1:0] q_nx_s;
    logic [XLEN-1:0] iter_res_s;
    logic            last_s;

    // Accept-time decode and one iteration step of multiply / restoring divide.
    always_comb begin
        fast_s     = fast_result(op, a, b);
        multi_s    = (op == OP_MUL) || (((op == OP_DIVU) || (op == OP_REMU)) && (b != {XLEN{1'b0}}));
        mul_sum_s  = acc_r + (b_r[0] ? a_r : {XLEN{1'b0}});
        rem_sh_s   = {acc_r, a_r[XLEN-1]};
        diff_s     = rem_sh_s - {1'b0, b_r};
        ge_s       = ~diff_s[XLEN];
        rem_nx_s   = ge_s ? diff_s[XLEN-1:0] : rem_sh_s[XLEN-1:0];
        q_nx_s     = {a_r[XLEN-2:0], ge_s};
        iter_res_s = (op_r == OP_MUL)  ? mul_sum_s :
                     (op_r == OP_DIVU) ? q_nx_s : rem_nx_s;
        last_s     = (cnt_r == CW'(XLEN - 1));
    end

    // Control FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= {XLEN{1'b0}};
            zero_r      <= 1'b1;
            op_r        <= 4'd0;
            a_r         <= {XLEN{1'b0}};
            b_r         <= {XLEN{1'b0}};
            acc_r       <= {XLEN{1'b0}};
            cnt_r       <= {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        op_r       <= op;
                        a_r        <= a;
                        b_r        <= b;
                        acc_r      <= {XLEN{1'b0}};
                        cnt_r      <= {CW{1'b0}};
                        in_ready_r <= 1'b0;
                        if (multi_s) begin
                            state_r <= BUSY;
                        end else begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                            result_r    <= fast_s;
                            zero_r      <= (fast_s == {XLEN{1'b0}});
                        end
                    end
                end
                BUSY: begin
                    cnt_r <= cnt_r + CW'(1);
                    if (op_r == OP_MUL) begin
                        acc_r <= mul_sum_s;
                        a_r   <= a_r << 1;
                        b_r   <= b_r >> 1;
                    end else begin
                        acc_r <= rem_nx_s;
                        a_r   <= q_nx_s;
                    end
                    if (last_s) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        result_r    <= iter_res_s;
                        zero_r      <= (iter_res_s == {XLEN{1'b0}});
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the combinational 64-bit ALU.
- Adds iterative multiply, unsigned divide and unsigned remainder, and registers every result.
- Uses valid/ready on both input and output, so the execute stage can stall on long operations.
- Single operation in flight; sits between decode/issue and writeback.

Parameters:
XLEN, 64, operand/result width in bits (legal: 8..64, even).

Ports:
clk  input  1  clock, all logic on rising edge
rstn  input  1  synchronous active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  unit can accept an operation
op  input  4  operation code
a  input  XLEN  operand A
b  input  XLEN  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  XLEN  registered result
zero  output  1  registered, 1 when result == 0

Behaviour:
- Opcodes:
  - 0 AND; 1 OR; 2 ADD (mod 2^XLEN); 6 SUB (a-b, mod 2^XLEN).
  - 7 SLT: signed a<b gives 1, else 0, zero-extended.
  - 12 NOR.
  - 8 MUL: low XLEN bits of unsigned a*b.
  - 10 DIVU: unsigned a/b. 11 REMU: unsigned a%b.
  - Any other code: result 0, single-cycle.
- Reset (rstn=0 at an edge):
  - State goes to IDLE; in_ready=1, out_valid=0, result=0, zero=1, iteration counter=0.
  - Any in-flight operation is discarded.
- FSM states IDLE, BUSY, DONE:
  - in_ready = (state==IDLE). No acceptance in BUSY or DONE.
  - Accept = in_valid && in_ready at edge T. Operands and op are latched; later changes on a/b/op are ignored.
- Single-cycle ops (0,1,2,6,7,12, illegal): IDLE->DONE at T. result/zero valid and out_valid=1 from T+1.
- MUL (iterative shift-add, one bit per cycle):
  - IDLE->BUSY at T.
  - Counter runs XLEN iterations, cycles T+1..T+XLEN.
  - BUSY->DONE at the edge ending the last iteration; out_valid=1 from T+XLEN+1.
- DIVU/REMU (restoring division, one quotient bit per cycle): same XLEN-iteration timing as MUL.
- Divide by zero (b==0), detected at accept:
  - DIVU returns all ones; REMU returns a.
  - Goes straight to DONE; out_valid=1 from T+1. No iteration.
- DONE:
  - result, zero and out_valid are held stable while out_ready=0 (backpressure, arbitrary duration).
  - Edge with out_valid && out_ready moves DONE->IDLE. out_valid=0 and in_ready=1 next cycle.
  - result keeps its last value after the handshake.
- Back-to-back throughput: at most one result every 2 cycles for single-cycle ops.
- zero always reflects the registered result, updated in the same cycle result updates.
- Iteration counter width: clog2(XLEN)+1.
- No overflow/carry flags. Signed mul/div is out of scope.

Test Plan:
- Logic and arithmetic: XLEN=64, a=5, b=12, out_ready=1. Each op accepted at T gives out_valid at T+1 with these results:
  - AND=4, OR=13, ADD=17.
  - SUB=0xFFFF_FFFF_FFFF_FFF9.
  - SLT=1.
  - NOR=0xFFFF_FFFF_FFFF_FFF2.
  - op=3 gives 0 with zero=1.
- Signed compare and wrap:
  - SLT a=-1, b=1 gives 1.
  - SLT a=1, b=-1 gives 0 with zero=1.
  - ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 gives 0 with zero=1.
- Multiply: MUL a=7, b=6 accepted at T.
  - in_ready=0 during T+1..T+64.
  - out_valid rises at T+65 with result=42.
  - MUL a=2^63, b=2 gives 0.
- Divide:
  - DIVU 100/7 gives 14; REMU 100%7 gives 2; each out_valid at T+65.
  - DIVU 5/0 gives 0xFFFF_FFFF_FFFF_FFFF at T+1.
  - REMU 5%0 gives 5 at T+1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after ADD 5+12. result=17 and out_valid=1 stay stable; in_valid is ignored while held.
  - After the handshake, in_ready=1 on the next cycle.
- Reset mid-operation: assert rstn=0 at T+20 of a DIVU.
  - Next cycle: in_ready=1, out_valid=0, result=0, zero=1.
  - A fresh ADD afterwards completes correctly.
